// File: rtl/tetris_pkg.sv
// Shared board defaults, scheduler state/op encodings and a state-class helper
// for the falling-piece move scheduler.
package tetris_pkg;

    localparam int DEF_BOARD_W = 10;
    localparam int DEF_BOARD_H = 20;
    localparam int DEF_SPAWN_X = 4;
    localparam int DEF_SPAWN_Y = 19;
    localparam int DEF_TIMEOUT = 64;

    localparam int POS_W = 5;
    localparam int ID_W  = 3;
    localparam int CNT_W = 7;

    typedef enum logic [2:0] {
        S_EMPTY  = 3'd0,
        S_ACTIVE = 3'd1,
        S_CLR    = 3'd2,
        S_WAIT   = 3'd3,
        S_COMMIT = 3'd4,
        S_LOCK   = 3'd5,
        S_OVER   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_SPAWN = 2'd0,
        OP_DN    = 2'd1,
        OP_L     = 2'd2,
        OP_R     = 2'd3
    } op_t;

    // Requests are only latched while a piece is live and not landing.
    function automatic logic accepts_requests(input state_t s);
        logic v;
        case (s)
            S_ACTIVE, S_CLR, S_WAIT, S_COMMIT: v = 1'b1;
            default:                           v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/move_req_arbiter.sv
// Sticky move-request bits with left/right cancellation and a fixed
// down > left > right grant toward the scheduler FSM.
module move_req_arbiter
    import tetris_pkg::*;
(
    input  logic clk,
    input  logic Reset,
    input  logic i_enable,
    input  logic i_flush,
    input  logic i_tick,
    input  logic i_left,
    input  logic i_right,
    input  logic i_consume,
    output logic o_grant_valid,
    output op_t  o_grant
);

    logic r_pend_dn;
    logic r_pend_l;
    logic r_pend_r;
    logic w_clr_dn;
    logic w_clr_l;
    logic w_clr_r;

    // Consuming down clears only down; otherwise both sideways bits are retired,
    // which also covers the opposing left/right cancel.
    always_comb begin
        w_clr_dn = 1'b0;
        w_clr_l  = 1'b0;
        w_clr_r  = 1'b0;
        if (i_consume) begin
            w_clr_dn = r_pend_dn;
            w_clr_l  = ~r_pend_dn & r_pend_l;
            w_clr_r  = ~r_pend_dn & r_pend_r;
        end else begin
            w_clr_dn = 1'b0;
        end
    end

    // Fixed-priority grant; opposing sideways requests produce no grant.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant       = OP_DN;
        if (r_pend_dn) begin
            o_grant_valid = 1'b1;
            o_grant       = OP_DN;
        end else if (r_pend_l && r_pend_r) begin
            o_grant_valid = 1'b0;
        end else if (r_pend_l) begin
            o_grant_valid = 1'b1;
            o_grant       = OP_L;
        end else if (r_pend_r) begin
            o_grant_valid = 1'b1;
            o_grant       = OP_R;
        end else begin
            o_grant_valid = 1'b0;
        end
    end

    // Pending bits: a same-cycle set overrides a clear.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_pend_dn <= 1'b0;
            r_pend_l  <= 1'b0;
            r_pend_r  <= 1'b0;
        end else if (i_flush) begin
            r_pend_dn <= 1'b0;
            r_pend_l  <= 1'b0;
            r_pend_r  <= 1'b0;
        end else begin
            r_pend_dn <= (r_pend_dn & ~w_clr_dn) | (i_enable & i_tick);
            r_pend_l  <= (r_pend_l  & ~w_clr_l)  | (i_enable & i_left);
            r_pend_r  <= (r_pend_r  & ~w_clr_r)  | (i_enable & i_right);
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// Drives the single collision checker for the active piece: spawns, gravity and
// sideways moves are checked one at a time, then committed, locked or game over.
module move_scheduler
    import tetris_pkg::*;
#(
    parameter int BOARD_W = DEF_BOARD_W,
    parameter int BOARD_H = DEF_BOARD_H,
    parameter int SPAWN_X = DEF_SPAWN_X,
    parameter int SPAWN_Y = DEF_SPAWN_Y,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             spawn,
    input  logic [ID_W-1:0]  spawn_id,
    input  logic             tick,
    input  logic             req_left,
    input  logic             req_right,
    output logic             chk_clr,
    output logic             chk_start,
    output logic [POS_W-1:0] chk_x,
    output logic [POS_W-1:0] chk_y,
    output logic [ID_W-1:0]  chk_id,
    input  logic             place,
    input  logic             noplace,
    output logic [POS_W-1:0] cur_x,
    output logic [POS_W-1:0] cur_y,
    output logic [ID_W-1:0]  cur_id,
    output logic             piece_valid,
    output logic             moved,
    output logic             lock,
    output logic             game_over,
    output logic             chk_timeout
);

    localparam logic [POS_W-1:0] L_X_MAX   = 5'(BOARD_W - 1);
    localparam logic [POS_W-1:0] L_SPAWN_X = 5'(SPAWN_X);
    localparam logic [POS_W-1:0] L_SPAWN_Y = (SPAWN_Y < BOARD_H) ? 5'(SPAWN_Y) : 5'(BOARD_H - 1);
    localparam logic [CNT_W-1:0] L_TMO_END = 7'(TIMEOUT - 1);

    state_t           r_state;
    op_t              r_op;
    logic [POS_W-1:0] r_cand_x;
    logic [POS_W-1:0] r_cand_y;
    logic [ID_W-1:0]  r_cand_id;
    logic [CNT_W-1:0] r_cnt;
    logic [POS_W-1:0] r_cur_x;
    logic [POS_W-1:0] r_cur_y;
    logic [ID_W-1:0]  r_cur_id;
    logic             r_piece_valid;
    logic             r_moved;
    logic             r_lock;
    logic             r_game_over;
    logic             r_chk_timeout;
    logic             r_chk_clr;
    logic             r_chk_start;
    logic [POS_W-1:0] r_chk_x;
    logic [POS_W-1:0] r_chk_y;
    logic [ID_W-1:0]  r_chk_id;

    logic             w_enable;
    logic             w_flush;
    logic             w_consume;
    logic             w_grant_valid;
    op_t              w_grant;

    assign w_enable  = accepts_requests(r_state);
    assign w_flush   = (r_state == S_EMPTY) || (r_state == S_LOCK) || (r_state == S_OVER);
    assign w_consume = (r_state == S_ACTIVE);

    move_req_arbiter u_arb (
        .clk           (clk),
        .Reset         (Reset),
        .i_enable      (w_enable),
        .i_flush       (w_flush),
        .i_tick        (tick),
        .i_left        (req_left),
        .i_right       (req_right),
        .i_consume     (w_consume),
        .o_grant_valid (w_grant_valid),
        .o_grant       (w_grant)
    );

    // Scheduler FSM with candidate, timeout counter and all registered outputs.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state       <= S_EMPTY;
            r_op          <= OP_SPAWN;
            r_cand_x      <= 5'd0;
            r_cand_y      <= 5'd0;
            r_cand_id     <= 3'd0;
            r_cnt         <= 7'd0;
            r_cur_x       <= 5'd0;
            r_cur_y       <= 5'd0;
            r_cur_id      <= 3'd0;
            r_piece_valid <= 1'b0;
            r_moved       <= 1'b0;
            r_lock        <= 1'b0;
            r_game_over   <= 1'b0;
            r_chk_timeout <= 1'b0;
            r_chk_clr     <= 1'b0;
            r_chk_start   <= 1'b0;
            r_chk_x       <= 5'd0;
            r_chk_y       <= 5'd0;
            r_chk_id      <= 3'd0;
        end else begin
            r_moved   <= 1'b0;
            r_lock    <= 1'b0;
            r_chk_clr <= 1'b0;
            case (r_state)
                S_EMPTY: begin
                    r_piece_valid <= 1'b0;
                    if (spawn) begin
                        r_cand_x  <= L_SPAWN_X;
                        r_cand_y  <= L_SPAWN_Y;
                        r_cand_id <= spawn_id;
                        r_op      <= OP_SPAWN;
                        r_chk_clr <= 1'b1;
                        r_state   <= S_CLR;
                    end
                end
                S_ACTIVE: begin
                    // Wall and floor guards are evaluated before any +/-1 so 5-bit
                    // arithmetic never wraps.
                    if (w_grant_valid) begin
                        r_cand_id <= r_cur_id;
                        r_op      <= w_grant;
                        case (w_grant)
                            OP_DN: begin
                                if (r_cur_y == 5'd0) begin
                                    r_state <= S_LOCK;
                                end else begin
                                    r_cand_x  <= r_cur_x;
                                    r_cand_y  <= r_cur_y - 5'd1;
                                    r_chk_clr <= 1'b1;
                                    r_state   <= S_CLR;
                                end
                            end
                            OP_L: begin
                                if (r_cur_x != 5'd0) begin
                                    r_cand_x  <= r_cur_x - 5'd1;
                                    r_cand_y  <= r_cur_y;
                                    r_chk_clr <= 1'b1;
                                    r_state   <= S_CLR;
                                end
                            end
                            OP_R: begin
                                if (r_cur_x != L_X_MAX) begin
                                    r_cand_x  <= r_cur_x + 5'd1;
                                    r_cand_y  <= r_cur_y;
                                    r_chk_clr <= 1'b1;
                                    r_state   <= S_CLR;
                                end
                            end
                            default: r_state <= S_ACTIVE;
                        endcase
                    end
                end
                S_CLR: begin
                    r_cnt       <= 7'd0;
                    r_chk_start <= 1'b1;
                    r_chk_x     <= r_cand_x;
                    r_chk_y     <= r_cand_y;
                    r_chk_id    <= r_cand_id;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (noplace && !place) begin
                        r_chk_start <= 1'b0;
                        r_chk_x     <= 5'd0;
                        r_chk_y     <= 5'd0;
                        r_chk_id    <= 3'd0;
                        r_state     <= S_COMMIT;
                    end else if (place || (r_cnt == L_TMO_END)) begin
                        // A checker that never answers is treated as blocked.
                        if (!place) begin
                            r_chk_timeout <= 1'b1;
                        end
                        r_chk_start <= 1'b0;
                        r_chk_x     <= 5'd0;
                        r_chk_y     <= 5'd0;
                        r_chk_id    <= 3'd0;
                        case (r_op)
                            OP_SPAWN: begin
                                r_game_over   <= 1'b1;
                                r_piece_valid <= 1'b0;
                                r_state       <= S_OVER;
                            end
                            OP_DN:   r_state <= S_LOCK;
                            default: r_state <= S_ACTIVE;
                        endcase
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_COMMIT: begin
                    r_cur_x       <= r_cand_x;
                    r_cur_y       <= r_cand_y;
                    r_cur_id      <= r_cand_id;
                    r_piece_valid <= 1'b1;
                    r_moved       <= 1'b1;
                    r_state       <= S_ACTIVE;
                end
                S_LOCK: begin
                    r_lock        <= 1'b1;
                    r_piece_valid <= 1'b0;
                    r_state       <= S_EMPTY;
                end
                S_OVER: begin
                    r_game_over   <= 1'b1;
                    r_piece_valid <= 1'b0;
                    r_state       <= S_OVER;
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign chk_clr     = r_chk_clr;
    assign chk_start   = r_chk_start;
    assign chk_x       = r_chk_x;
    assign chk_y       = r_chk_y;
    assign chk_id      = r_chk_id;
    assign cur_x       = r_cur_x;
    assign cur_y       = r_cur_y;
    assign cur_id      = r_cur_id;
    assign piece_valid = r_piece_valid;
    assign moved       = r_moved;
    assign lock        = r_lock;
    assign game_over   = r_game_over;
    assign chk_timeout = r_chk_timeout;

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler: stimulus queues expected checker
// candidates and commit/lock events; a monitor pops and compares them.
module tb_move_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spawn, tick, req_left, req_right, place, noplace;
    logic [2:0] spawn_id;
    logic       chk_clr, chk_start, piece_valid, moved, lock, game_over, chk_timeout;
    logic [4:0] chk_x, chk_y, cur_x, cur_y;
    logic [2:0] chk_id, cur_id;

    always #5 clk = ~clk;

    move_scheduler dut (
        .clk(clk), .Reset(rst_n), .spawn(spawn), .spawn_id(spawn_id), .tick(tick),
        .req_left(req_left), .req_right(req_right), .chk_clr(chk_clr), .chk_start(chk_start),
        .chk_x(chk_x), .chk_y(chk_y), .chk_id(chk_id), .place(place), .noplace(noplace),
        .cur_x(cur_x), .cur_y(cur_y), .cur_id(cur_id), .piece_valid(piece_valid),
        .moved(moved), .lock(lock), .game_over(game_over), .chk_timeout(chk_timeout)
    );

    typedef struct { bit is_lock; logic [4:0] x; logic [4:0] y; logic [2:0] id; } ev_t;
    typedef struct { logic [4:0] x; logic [4:0] y; logic [2:0] id; } cand_t;

    ev_t   ev_q[$];
    cand_t cand_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    n_starts = 0;
    int    n_clr_since = 0;
    int    n_clr_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic expect_cand(input int x, input int y, input int id);
        cand_t c;
        c.x = 5'(x); c.y = 5'(y); c.id = 3'(id);
        cand_q.push_back(c);
    endtask

    task automatic expect_ev(input bit is_lock, input int x, input int y, input int id);
        ev_t e;
        e.is_lock = is_lock; e.x = 5'(x); e.y = 5'(y); e.id = 3'(id);
        ev_q.push_back(e);
    endtask

    task automatic expect_move(input int x, input int y, input int id);
        expect_cand(x, y, id);
        expect_ev(1'b0, x, y, id);
    endtask

    task automatic pulse(input bit s, input bit t, input bit l, input bit r, input logic [2:0] id);
        @(negedge clk);
        spawn = s; tick = t; req_left = l; req_right = r; spawn_id = id;
        @(negedge clk);
        spawn = 1'b0; tick = 1'b0; req_left = 1'b0; req_right = 1'b0;
    endtask

    task automatic wait_start();
        int i = 0;
        while (!chk_start && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("chk_start_seen", chk_start, 1);
    endtask

    task automatic respond(input bit blocked, input int delay);
        wait_start();
        repeat (delay) @(negedge clk);
        if (blocked) place = 1'b1;
        else noplace = 1'b1;
        @(negedge clk);
        place = 1'b0; noplace = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Monitor: checker candidates on each new check, commit/lock events on pulses.
    initial begin
        logic  prev_start;
        cand_t c;
        ev_t   e;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_clr) begin
                n_clr_since++;
                n_clr_total++;
            end
            if (chk_start && !prev_start) begin
                n_starts++;
                check("clr_pulses_before_start", n_clr_since, 1);
                n_clr_since = 0;
                check("cand_expected", cand_q.size() > 0, 1);
                if (cand_q.size() > 0) begin
                    c = cand_q.pop_front();
                    check("chk_x", chk_x, c.x);
                    check("chk_y", chk_y, c.y);
                    check("chk_id", chk_id, c.id);
                end
            end
            prev_start = chk_start;
            if (moved || lock) begin
                check("event_expected", ev_q.size() > 0, 1);
                if (ev_q.size() > 0) begin
                    e = ev_q.pop_front();
                    check("ev_is_lock", lock, e.is_lock);
                    check("ev_x", cur_x, e.x);
                    check("ev_y", cur_y, e.y);
                    check("ev_id", cur_id, e.id);
                    check("ev_piece_valid", piece_valid, !e.is_lock);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int c0;
        int n;
        rst_n = 1'b0; spawn = 1'b0; tick = 1'b0; req_left = 1'b0; req_right = 1'b0;
        place = 1'b0; noplace = 1'b0; spawn_id = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_chk", {chk_clr, chk_start, chk_x, chk_y, chk_id}, 0);
        check("rst_cur", {cur_x, cur_y, cur_id, piece_valid, moved, lock, game_over, chk_timeout}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Spawn, checker answers clear after two cycles.
        expect_move(4, 19, 1);
        pulse(1, 0, 0, 0, 3'd1);
        respond(0, 2);
        check("spawn_cur_x", cur_x, 4);
        check("spawn_cur_y", cur_y, 19);
        check("spawn_cur_id", cur_id, 1);
        check("spawn_valid", piece_valid, 1);

        // Gravity to the floor, then a tick at y=0 locks without a check.
        for (int y = 18; y >= 0; y--) begin
            expect_move(4, y, 1);
            pulse(0, 1, 0, 0, 3'd0);
            respond(0, (y == 18) ? 1 : 0);
        end
        check("floor_y", cur_y, 0);
        s0 = n_starts;
        expect_ev(1'b1, 4, 0, 1);
        pulse(0, 1, 0, 0, 3'd0);
        repeat (4) @(negedge clk);
        check("floor_no_check", n_starts, s0);
        check("floor_valid", piece_valid, 0);

        // Blocked gravity locks in place; next spawn accepted.
        expect_move(4, 19, 2);
        pulse(1, 0, 0, 0, 3'd2);
        respond(0, 1);
        for (int y = 18; y >= 5; y--) begin
            expect_move(4, y, 2);
            pulse(0, 1, 0, 0, 3'd0);
            respond(0, 0);
        end
        expect_cand(4, 4, 2);
        expect_ev(1'b1, 4, 5, 2);
        pulse(0, 1, 0, 0, 3'd0);
        respond(1, 1);
        check("blocked_cur_y", cur_y, 5);
        check("blocked_cur_x", cur_x, 4);
        expect_move(4, 19, 3);
        pulse(1, 0, 0, 0, 3'd3);
        respond(0, 0);
        check("respawn_valid", piece_valid, 1);

        // Sideways moves, walls, opposing cancel, down-before-left.
        for (int x = 3; x >= 0; x--) begin
            expect_move(x, 19, 3);
            pulse(0, 0, 1, 0, 3'd0);
            respond(0, 0);
        end
        c0 = n_clr_total;
        pulse(0, 0, 1, 0, 3'd0);
        repeat (4) @(negedge clk);
        check("left_wall_no_clr", n_clr_total, c0);
        check("left_wall_x", cur_x, 0);
        pulse(0, 0, 1, 1, 3'd0);
        repeat (4) @(negedge clk);
        check("lr_cancel_no_clr", n_clr_total, c0);
        check("lr_cancel_x", cur_x, 0);
        expect_move(1, 19, 3);
        pulse(0, 0, 0, 1, 3'd0);
        respond(0, 0);
        expect_move(1, 18, 3);
        expect_move(0, 18, 3);
        pulse(0, 1, 1, 0, 3'd0);
        respond(0, 0);
        respond(0, 0);
        check("dn_then_l_x", cur_x, 0);
        check("dn_then_l_y", cur_y, 18);
        for (int x = 1; x <= 9; x++) begin
            expect_move(x, 18, 3);
            pulse(0, 0, 0, 1, 3'd0);
            respond(0, 0);
        end
        c0 = n_clr_total;
        pulse(0, 0, 0, 1, 3'd0);
        repeat (4) @(negedge clk);
        check("right_wall_no_clr", n_clr_total, c0);
        check("right_wall_x", cur_x, 9);

        // Lock, then a blocked spawn ends the game; further requests ignored.
        expect_cand(9, 17, 3);
        expect_ev(1'b1, 9, 18, 3);
        pulse(0, 1, 0, 0, 3'd0);
        respond(1, 0);
        expect_cand(4, 19, 5);
        pulse(1, 0, 0, 0, 3'd5);
        respond(1, 2);
        check("over_flag", game_over, 1);
        check("over_valid", piece_valid, 0);
        s0 = n_starts;
        pulse(1, 1, 0, 0, 3'd6);
        repeat (6) @(negedge clk);
        check("over_ignores", n_starts, s0);
        check("over_sticky", game_over, 1);

        // Reset clears game over; silent checker times out and locks.
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_clears_over", game_over, 0);
        rst_n = 1'b1;
        @(negedge clk);
        expect_move(4, 19, 6);
        pulse(1, 0, 0, 0, 3'd6);
        respond(0, 0);
        expect_cand(4, 18, 6);
        expect_ev(1'b1, 4, 19, 6);
        pulse(0, 1, 0, 0, 3'd0);
        wait_start();
        n = 0;
        while (chk_start && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("timeout_wait_cycles", n, 64);
        check("timeout_flag", chk_timeout, 1);
        repeat (3) @(negedge clk);
        check("timeout_locked_valid", piece_valid, 0);
        check("timeout_sticky", chk_timeout, 1);

        // Reset asserted mid-check drops every output at once.
        expect_cand(4, 19, 7);
        pulse(1, 0, 0, 0, 3'd7);
        wait_start();
        repeat (3) @(negedge clk);
        check("midwait_start", chk_start, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_chk", {chk_clr, chk_start, chk_x, chk_y, chk_id}, 0);
        check("async_rst_cur", {cur_x, cur_y, cur_id, piece_valid, moved, lock, game_over, chk_timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("ev_q_drained", ev_q.size(), 0);
        check("cand_q_drained", cand_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
